// File: rtl/risc16_alu_arbiter_pkg.sv
// Shared definitions for the RiSC16 ALU arbiter: ALU function codes and arbiter FSM encodings.
// The optional grant statistics are enabled with RISC16_ALU_ARB_STATS_EN.
`ifndef ALU_FUNCT_LEN
`define ALU_FUNCT_LEN 2
`endif
`ifndef ALU_ADD
`define ALU_ADD 2'd0
`endif
`ifndef ALU_NAND
`define ALU_NAND 2'd1
`endif
`ifndef ALU_PASS1
`define ALU_PASS1 2'd2
`endif
`ifndef ALU_EQ
`define ALU_EQ 2'd3
`endif

package risc16_alu_arbiter_pkg;

    localparam int unsigned ALU_FUNCT_LEN = `ALU_FUNCT_LEN;
    localparam int unsigned CNT_W         = 16;

    localparam logic [ALU_FUNCT_LEN-1:0] ALU_ADD   = `ALU_ADD;
    localparam logic [ALU_FUNCT_LEN-1:0] ALU_NAND  = `ALU_NAND;
    localparam logic [ALU_FUNCT_LEN-1:0] ALU_PASS1 = `ALU_PASS1;
    localparam logic [ALU_FUNCT_LEN-1:0] ALU_EQ    = `ALU_EQ;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/RiSC16_alu.sv
// Combinational RiSC16 ALU shared by the arbiter's requesters.
module RiSC16_alu
    import risc16_alu_arbiter_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = 16
) (
    input  logic [WORD_LENGTH-1:0]   src1,
    input  logic [WORD_LENGTH-1:0]   src2,
    input  logic [ALU_FUNCT_LEN-1:0] funct,
    output logic [WORD_LENGTH-1:0]   result,
    output logic                     state
);

    // EQ yields a zero result and a raised state flag when the operands match.
    always_comb begin
        result = '0;
        state  = 1'b0;
        case (funct)
            ALU_ADD:   result = WORD_LENGTH'(src1 + src2);
            ALU_NAND:  result = ~(src1 & src2);
            ALU_PASS1: result = src1;
            ALU_EQ: begin
                result = src1 ^ src2;
                state  = (src1 == src2);
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/risc16_alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module risc16_alu_arbiter_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    int unsigned          sel;

    // Rotate so bit 0 is the requester at ptr, then take the lowest set bit.
    always_comb begin
        req_dbl = {req, req};
        req_rot = NUM_REQ'(req_dbl >> ptr);
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sel     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (en && !gnt_any && req_rot[k]) begin
                gnt_any = 1'b1;
                sel     = 32'(ptr) + k;
            end
        end
        if (sel >= NUM_REQ) begin
            sel = sel - NUM_REQ;
        end
        if (gnt_any) begin
            gnt     = NUM_REQ'(1) << sel;
            gnt_idx = ID_W'(sel);
        end
    end

endmodule

// File: rtl/risc16_alu_arbiter.sv
// Round-robin arbiter sharing one RiSC16_alu between NUM_REQ requesters, one op in flight.
// Define RISC16_ALU_ARB_STATS_EN to add per-requester saturating grant counters.
module risc16_alu_arbiter
    import risc16_alu_arbiter_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = 16,
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned ID_W        = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*WORD_LENGTH-1:0]   req_src1,
    input  logic [NUM_REQ*WORD_LENGTH-1:0]   req_src2,
    input  logic [NUM_REQ*ALU_FUNCT_LEN-1:0] req_funct,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ID_W-1:0]                  rsp_id,
    output logic [WORD_LENGTH-1:0]           rsp_result,
    output logic                             rsp_state
`ifdef RISC16_ALU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]         grant_count
`endif
);

    arb_state_e               state_q, state_d;
    logic [ID_W-1:0]          ptr_q, ptr_d;
    logic [WORD_LENGTH-1:0]   src1_q, src1_d;
    logic [WORD_LENGTH-1:0]   src2_q, src2_d;
    logic [ALU_FUNCT_LEN-1:0] funct_q, funct_d;
    logic [ID_W-1:0]          id_q, id_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]          rsp_id_q, rsp_id_d;
    logic [WORD_LENGTH-1:0]   rsp_result_q, rsp_result_d;
    logic                     rsp_state_q, rsp_state_d;

    logic [NUM_REQ-1:0]       gnt;
    logic [ID_W-1:0]          gnt_idx;
    logic                     gnt_any;
    logic                     arb_en;
    logic [WORD_LENGTH-1:0]   sel_src1, sel_src2;
    logic [ALU_FUNCT_LEN-1:0] sel_funct;
    logic [WORD_LENGTH-1:0]   alu_result;
    logic                     alu_state;

    assign arb_en = (state_q == ARB_IDLE);

    risc16_alu_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    RiSC16_alu #(
        .WORD_LENGTH (WORD_LENGTH)
    ) u_alu (
        .src1   (src1_q),
        .src2   (src2_q),
        .funct  (funct_q),
        .result (alu_result),
        .state  (alu_state)
    );

    // Pick the winner's slice out of the flattened request buses.
    always_comb begin
        sel_src1  = '0;
        sel_src2  = '0;
        sel_funct = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_src1  = req_src1[i*WORD_LENGTH +: WORD_LENGTH];
                sel_src2  = req_src2[i*WORD_LENGTH +: WORD_LENGTH];
                sel_funct = req_funct[i*ALU_FUNCT_LEN +: ALU_FUNCT_LEN];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (gnt_any) state_d = ARB_EXEC;
            ARB_EXEC: state_d = ARB_RESP;
            ARB_RESP: if (rsp_ready) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = gnt;
        ptr_d        = ptr_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        funct_d      = funct_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_state_d  = rsp_state_q;
        case (state_q)
            ARB_IDLE: begin
                if (gnt_any) begin
                    src1_d  = sel_src1;
                    src2_d  = sel_src2;
                    funct_d = sel_funct;
                    id_d    = gnt_idx;
                end
            end
            ARB_EXEC: begin
                rsp_valid_d  = 1'b1;
                rsp_id_d     = id_q;
                rsp_result_d = alu_result;
                rsp_state_d  = alu_state;
            end
            ARB_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ptr_d       = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q        <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            funct_q      <= '0;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_state_q  <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            funct_q      <= funct_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_state_q  <= rsp_state_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_state  = rsp_state_q;

`ifdef RISC16_ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_REQ];
    logic [CNT_W-1:0] cnt_d [NUM_REQ];

    // Counters saturate rather than wrap so a long run never reports a small count.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (gnt[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        grant_count = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_count[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_risc16_alu_arbiter.sv
// Randomized scoreboard bench for risc16_alu_arbiter; grant counters checked when
// RISC16_ALU_ARB_STATS_EN is defined.
module tb_risc16_alu_arbiter;
    import risc16_alu_arbiter_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned N  = 2;
    localparam int unsigned IW = 1;
    localparam int unsigned FL = ALU_FUNCT_LEN;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_src1;
    logic [N*W-1:0]  req_src2;
    logic [N*FL-1:0] req_funct;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [W-1:0]    rsp_result;
    logic            rsp_state;
`ifdef RISC16_ALU_ARB_STATS_EN
    logic [N*16-1:0] grant_count;
`endif

    always #5 clk = ~clk;

    risc16_alu_arbiter #(.WORD_LENGTH(W), .NUM_REQ(N), .ID_W(IW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .req_funct  (req_funct),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_state  (rsp_state)
`ifdef RISC16_ALU_ARB_STATS_EN
        ,
        .grant_count(grant_count)
`endif
    );

    typedef struct {
        int unsigned  id;
        logic [W-1:0] res;
        logic         st;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    int unsigned  m_ptr = 0;
    bit           m_busy = 1'b0;
    bit           seen = 1'b0;
    int unsigned  m_cnt[N];
    int           last_gnt = -1;

    bit           cv[N];
    logic [W-1:0] c1[N];
    logic [W-1:0] c2[N];
    logic [FL-1:0] cf[N];
    bit           c_rr = 1'b1;

    always @(posedge clk) cyc++;

    function automatic logic [W:0] alu_ref(input logic [FL-1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned sum;
        sum = (32'(a) + 32'(b)) % 65536;
        case (f)
            ALU_ADD:   return {1'b0, W'(sum)};
            ALU_NAND:  return {1'b0, ~(a & b)};
            ALU_PASS1: return {1'b0, a};
            default:   return {(a == b), (a == b) ? W'(0) : (a ^ b)};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive_ports();
        for (int i = 0; i < N; i++) begin
            req_valid[i]             = cv[i];
            req_src1[i*W +: W]       = c1[i];
            req_src2[i*W +: W]       = c2[i];
            req_funct[i*FL +: FL]    = cf[i];
        end
        rsp_ready = c_rr;
    endtask

    task automatic new_op(input int i);
        c1[i] = W'($urandom);
        c2[i] = ($urandom_range(0, 3) == 0) ? c1[i] : W'($urandom);
        cf[i] = FL'($urandom_range(0, 3));
    endtask

    // One cycle: drive at the falling edge, then predict and check the grant.
    task automatic step();
        logic [N-1:0] er;
        logic [W-1:0] res;
        logic         st;
        int           g;
        @(negedge clk);
        drive_ports();
        #2;
        er = '0;
        g  = -1;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (int'(m_ptr) + k) % N;
                if (g < 0 && cv[j]) g = j;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        last_gnt = g;
        if (g >= 0) begin
            {st, res} = alu_ref(cf[g], c1[g], c2[g]);
            sb.push_back('{id: g, res: res, st: st, cyc: cyc});
            m_busy = 1'b1;
            m_cnt[g]++;
        end
    endtask

    task automatic set_op(input int i, input logic [FL-1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        cv[i] = 1'b1;
        cf[i] = f;
        c1[i] = a;
        c2[i] = b;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) cv[i] = 1'b0;
    endtask

    // Asynchronous reset away from any clock edge; the model forgets everything in flight.
    task automatic reset_now(input string nm);
        reset_n = 1'b0;
        #1;
        chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({nm, "_rsp_result"}, 32'(rsp_result), 32'd0);
        chk({nm, "_rsp_id"}, 32'(rsp_id), 32'd0);
        sb.delete();
        seen   = 1'b0;
        m_busy = 1'b0;
        m_ptr  = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        idle_all();
        drive_ports();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Response monitor: compares whatever the DUT presents against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!reset_n) continue;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    if (!seen) begin
                        chk("latency", 32'(cyc - sb[0].cyc), 32'd2);
                        seen = 1'b1;
                    end
                    chk("rsp_id", 32'(rsp_id), sb[0].id);
                    chk("rsp_result", 32'(rsp_result), 32'(sb[0].res));
                    chk("rsp_state", 32'(rsp_state), 32'(sb[0].st));
                    if (rsp_ready) begin
                        m_ptr  = (sb[0].id + 1) % N;
                        m_busy = 1'b0;
                        seen   = 1'b0;
                        void'(sb.pop_front());
                    end
                end
            end else if (sb.size() > 0 && (seen || (cyc - sb[0].cyc) > 2)) begin
                chk("rsp_missing", 32'(rsp_valid), 32'd1);
                m_busy = 1'b0;
                seen   = 1'b0;
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            cv[i] = 1'b0; c1[i] = '0; c2[i] = '0; cf[i] = '0; m_cnt[i] = 0;
        end
        reset_n = 1'b0;
        drive_ports();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_result", 32'(rsp_result), 32'd0);
        chk("reset_rsp_state", 32'(rsp_state), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single ADD 102+205, then scramble operands after acceptance.
        set_op(0, ALU_ADD, 16'd102, 16'd205);
        step();
        chk("add_expect_0133", 32'(sb.size() > 0 ? sb[0].res : 16'h0), 32'h0133);
        idle_all();
        c1[0] = 16'hdead;
        repeat (4) step();

        // Backpressure for five cycles while requester 1 waits.
        set_op(0, ALU_NAND, 16'h0f0f, 16'h00ff);
        step();
        idle_all();
        c_rr = 1'b0;
        repeat (2) step();
        set_op(1, ALU_PASS1, 16'h1234, 16'h0);
        repeat (5) step();
        c_rr = 1'b1;
        step();
        repeat (2) step();
        idle_all();
        repeat (4) step();

        // Contention: both hold valid, grants must alternate.
        set_op(0, ALU_ADD, 16'd1, 16'd1);
        set_op(1, ALU_ADD, 16'd2, 16'd2);
        repeat (12) step();
        idle_all();
        repeat (4) step();

        // State flag pass-through.
        set_op(0, ALU_EQ, 16'h0005, 16'h0005);
        step();
        idle_all();
        repeat (3) step();
        set_op(0, ALU_EQ, 16'h0005, 16'h0006);
        step();
        idle_all();
        repeat (3) step();

        // Random traffic with random response backpressure.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < N; i++) begin
                if (last_gnt == i) begin
                    new_op(i);
                    cv[i] = ($urandom_range(0, 1) == 1);
                end else if (cv[i]) begin
                    if ($urandom_range(0, 9) == 0) cv[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    new_op(i);
                    cv[i] = 1'b1;
                end
            end
            c_rr = ($urandom_range(0, 3) != 0);
            step();
        end
        idle_all();
        c_rr = 1'b1;
        repeat (6) step();

        // Leave the pointer at 1, then reset during EXEC.
        set_op(0, ALU_PASS1, 16'h0042, 16'h0);
        step();
        idle_all();
        repeat (3) step();
        set_op(0, ALU_ADD, 16'd3, 16'd4);
        step();
        @(posedge clk);
        #1;
        reset_now("rst_exec");
        repeat (3) step();
        set_op(0, ALU_ADD, 16'd10, 16'd20);
        set_op(1, ALU_ADD, 16'd30, 16'd40);
        step();
        chk("post_reset_winner", 32'(last_gnt), 32'd0);
        idle_all();
        repeat (4) step();

        // Reset while a response is held under backpressure.
        set_op(1, ALU_NAND, 16'hffff, 16'h00f0);
        step();
        idle_all();
        c_rr = 1'b0;
        repeat (3) step();
        #2;
        reset_now("rst_resp");
        c_rr = 1'b1;
        repeat (4) step();

        // Grants since the last reset.
        set_op(1, ALU_ADD, 16'd5, 16'd6);
        for (int n = 0; n < 9; n++) step();
        idle_all();
        repeat (6) step();
        chk("drain", 32'(sb.size()), 32'd0);
`ifdef RISC16_ALU_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            chk("grant_count", 32'(grant_count[i*16 +: 16]), 32'(m_cnt[i]));
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
